aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES encryption controller that time-multiplexes one external combinational round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) across all NR rounds of a block.
- Owns the 128-bit state register, the round counter and the in/out valid-ready handshakes.
- Requests round keys by index from an external key store.
- Sits between the block-level host interface and the round datapath/key schedule.

Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256).
- RK_IDX_W, 4, width of round-key index; must satisfy 2**RK_IDX_W > NR.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  sequencer can accept a block.
- in_block  in  128  plaintext, FIPS-197 byte order (byte 0 in [127:120]).
- rk_idx  out  RK_IDX_W  round-key index requested this cycle.
- rk_data  in  128  round key for rk_idx, valid combinationally in the same cycle.
- round_in  out  128  state presented to the round datapath.
- round_final  out  1  high when the datapath must bypass MixColumns (last round).
- round_out  in  128  combinational datapath result for round_in/rk_data/round_final.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_block  out  128  ciphertext.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset: asynchronous on reset_n low, regardless of the operation in progress.
  - FSM=IDLE, state_reg=0, rnd=0.
  - in_ready=1 after release, out_valid=0, busy=0, round_final=0, rk_idx=0, round_in=0, out_block=0.
  - An in-flight block is discarded; no partial output ever appears.
- FSM states:
  - IDLE:
    - in_ready=1, rk_idx=0.
    - On in_valid & in_ready: state_reg <= in_block ^ rk_data (initial AddRoundKey), rnd <= 1, -> ROUND.
  - ROUND:
    - in_ready=0, rk_idx=rnd, round_in=state_reg, round_final=(rnd==NR).
    - Each cycle: state_reg <= round_out.
    - If rnd==NR -> DONE, else rnd <= rnd+1.
  - DONE:
    - out_valid=1, out_block=state_reg; state_reg and out_block held stable while out_ready=0.
    - On out_ready: -> IDLE, rnd <= 0.
- Outputs outside ROUND: round_in=state_reg, round_final=0.
- Latency and throughput:
  - out_valid rises exactly NR cycles after the accepting edge.
  - Minimum initiation interval is NR+2 cycles; no overlap between blocks.
- Handshake rules:
  - in_valid while not IDLE is ignored; in_block is not sampled.
  - out_valid never drops without out_ready.
  - out_ready while out_valid=0 has no effect.
  - Acceptance in IDLE is independent of out_ready.
- Simultaneous events: DONE with out_ready=1 returns to IDLE on that edge. A new block offered in that same cycle is not accepted until the following cycle, because in_ready is 0 in DONE.
- rk_idx: increments monotonically 0,1,...,NR per block, with no skips or repeats; the rk_idx width is fixed by the RK_IDX_W parameter.
- rnd never exceeds NR; no wrap-around path exists.

Test Plan:
- NR=10, bench round datapath and FIPS-197 key schedule, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, out_ready=1 -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after acceptance, rk_idx sequence 0..10, round_final high only at rk_idx=10.
- NR=14, key 000102...1f, same plaintext -> out_block=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Hold out_ready=0 for 7 cycles after out_valid -> out_valid and out_block stable, in_ready=0, busy=1; release -> IDLE next cycle, in_ready=1.
- in_valid held high continuously with changing in_block -> only the block present at each IDLE acceptance edge is encrypted; back-to-back blocks start every 12 cycles (NR=10, out_ready=1).
- Assert reset_n low at round 5, asynchronously between edges -> out_valid=0, in_ready=1, busy=0 immediately. After release, the FIPS-197 vector again yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- out_ready pulsed while IDLE and in ROUND -> no state change, no spurious out_valid.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES encryption controller. One external combinational round
// datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) is reused for
// all NR rounds of a block. This block owns the 128-bit working state, the
// round counter and the host-side valid/ready handshakes. It also requests
// round keys by index from an external key store.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     plaintext block offered
//   in_ready     sequencer can accept a block (IDLE only)
//   in_block     plaintext, FIPS-197 byte order (byte 0 in [127:120])
//   rk_idx       round-key index requested this cycle
//   rk_data      round key for rk_idx, valid combinationally in the same cycle
//   round_in     working state presented to the round datapath
//   round_final  last round: datapath must bypass MixColumns
//   round_out    combinational datapath result
//   out_valid    ciphertext available
//   out_ready    consumer accepts ciphertext
//   out_block    ciphertext (zero whenever out_valid is low)
//   busy         high while a block is being processed or awaiting pickup
//
// Timing: the accepting edge performs the initial AddRoundKey. Rounds 1..NR
// follow on consecutive edges. out_valid rises NR cycles after acceptance.
// All outputs are driven directly from flops. Their next values are derived
// from the next FSM state, so they change on the same edge as the FSM.
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR       = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_block,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic [127:0]        round_in,
    output logic                round_final,
    input  logic [127:0]        round_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ROUND = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam logic [RK_IDX_W-1:0] NR_IDX   = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] RND_ZERO = {RK_IDX_W{1'b0}};
    localparam logic [RK_IDX_W-1:0] RND_ONE  = {{(RK_IDX_W-1){1'b0}}, 1'b1};

    state_e                fsm_q, fsm_d;
    logic [RK_IDX_W-1:0]   rnd_q, rnd_d;
    logic [127:0]          data_q, data_d;

    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [127:0]          out_block_q, out_block_d;
    logic                  round_final_q, round_final_d;
    logic [RK_IDX_W-1:0]   rk_idx_q, rk_idx_d;

    // Next-state logic for the FSM, the round counter and the working state.
    always_comb begin
        fsm_d  = fsm_q;
        rnd_d  = rnd_q;
        data_d = data_q;
        case (fsm_q)
            S_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone is the handshake.
                // rk_idx is 0 here, so rk_data is the whitening key.
                if (in_valid) begin
                    data_d = in_block ^ rk_data;
                    rnd_d  = RND_ONE;
                    fsm_d  = S_ROUND;
                end else begin
                    rnd_d  = RND_ZERO;
                end
            end
            S_ROUND: begin
                data_d = round_out;
                // The >= comparison leaves the loop even if rnd_q was corrupted
                // past NR. The counter therefore never wraps.
                if (rnd_q >= NR_IDX) begin
                    fsm_d = S_DONE;
                end else begin
                    rnd_d = rnd_q + RND_ONE;
                end
            end
            S_DONE: begin
                // The result stays frozen until the consumer takes it.
                if (out_ready) begin
                    fsm_d = S_IDLE;
                    rnd_d = RND_ZERO;
                end else begin
                    fsm_d = S_DONE;
                end
            end
            default: begin
                fsm_d  = S_IDLE;
                rnd_d  = RND_ZERO;
                data_d = 128'h0;
            end
        endcase
    end

    // Registered-output next values, decoded from the next FSM state.
    always_comb begin
        in_ready_d    = (fsm_d == S_IDLE);
        busy_d        = (fsm_d == S_ROUND) || (fsm_d == S_DONE);
        out_valid_d   = (fsm_d == S_DONE);
        out_block_d   = (fsm_d == S_DONE) ? data_d : 128'h0;
        round_final_d = (fsm_d == S_ROUND) && (rnd_d == NR_IDX);
        rk_idx_d      = (fsm_d == S_ROUND) ? rnd_d : RND_ZERO;
    end

    // State, counter and output flops. Reset is asynchronous and immediate.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q         <= S_IDLE;
            rnd_q         <= RND_ZERO;
            data_q        <= 128'h0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_block_q   <= 128'h0;
            round_final_q <= 1'b0;
            rk_idx_q      <= RND_ZERO;
        end else begin
            fsm_q         <= fsm_d;
            rnd_q         <= rnd_d;
            data_q        <= data_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_block_q   <= out_block_d;
            round_final_q <= round_final_d;
            rk_idx_q      <= rk_idx_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_block   = out_block_q;
    assign round_final = round_final_q;
    assign rk_idx      = rk_idx_q;
    assign round_in    = data_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Self-checking bench. Two sequencers are built: an NR=10 instance fed an
// AES-128 key schedule and an NR=14 instance fed an AES-256 key schedule.
// Both share a behavioural AES round datapath. Expected ciphertexts for the
// NR=10 instance go through a queue. They are retired by a monitor on every
// output handshake.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128  = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT10    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT14    = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0, busy_a, round_final_a;
    logic [127:0] in_block_a = 128'h0, rk_data_a, round_in_a, round_out_a, out_block_a;
    logic [3:0]   rk_idx_a;

    logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0, busy_b, round_final_b;
    logic [127:0] in_block_b = 128'h0, rk_data_b, round_in_b, round_out_b, out_block_b;
    logic [3:0]   rk_idx_b;

    logic [31:0]         kw [0:59];
    logic [128*11-1:0]   rk10_flat = '0;
    logic [128*15-1:0]   rk14_flat = '0;

    logic [127:0] sb_a [$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .RK_IDX_W(4)) dut_a (
        .clock(clk), .reset_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_block(in_block_a),
        .rk_idx(rk_idx_a), .rk_data(rk_data_a),
        .round_in(round_in_a), .round_final(round_final_a), .round_out(round_out_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_block(out_block_a),
        .busy(busy_a)
    );

    aes_round_sequencer #(.NR(14), .RK_IDX_W(4)) dut_b (
        .clock(clk), .reset_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
        .rk_idx(rk_idx_b), .rk_data(rk_data_b),
        .round_in(round_in_b), .round_final(round_final_b), .round_out(round_out_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_block(out_block_b),
        .busy(busy_b)
    );

    // ---------------- behavioural AES model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv, base, e;
        inv = 8'h01; base = v; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   m0, m1, m2, m3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int cc = 0; cc < 4; cc++)
            for (int rr = 0; rr < 4; rr++)
                t[4*cc+rr] = a[4*((cc+rr)%4)+rr];
        if (!fin) begin
            for (int cc = 0; cc < 4; cc++) begin
                m0 = t[4*cc]; m1 = t[4*cc+1]; m2 = t[4*cc+2]; m3 = t[4*cc+3];
                t[4*cc]   = gmul(m0, 8'h02) ^ gmul(m1, 8'h03) ^ m2 ^ m3;
                t[4*cc+1] = m0 ^ gmul(m1, 8'h02) ^ gmul(m2, 8'h03) ^ m3;
                t[4*cc+2] = m0 ^ m1 ^ gmul(m2, 8'h02) ^ gmul(m3, 8'h03);
                t[4*cc+3] = gmul(m0, 8'h03) ^ m1 ^ m2 ^ gmul(m3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
        return res ^ k;
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = kw[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            kw[i] = tmp ^ kw[i-nk];
        end
    endtask

    function automatic logic [127:0] enc10(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk10_flat[127:0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, rk10_flat[128*r +: 128], r == 10);
        return s;
    endfunction

    // Key stores and round datapaths seen by the two DUTs.
    assign rk_data_a   = (rk_idx_a <= 4'd10) ? rk10_flat[128*rk_idx_a +: 128] : 128'h0;
    assign rk_data_b   = (rk_idx_b <= 4'd14) ? rk14_flat[128*rk_idx_b +: 128] : 128'h0;
    assign round_out_a = aes_round(round_in_a, rk_data_a, round_final_a);
    assign round_out_b = aes_round(round_in_b, rk_data_b, round_final_b);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: each output handshake retires the oldest expected block.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_output", {127'h0, out_valid_a}, 128'h0);
            end else begin
                chk("a_sb_out_block", out_block_a, sb_a.pop_front());
            end
        end
    end

    // One block through the NR=10 instance; optionally stall the consumer for 'hold' cycles.
    task automatic run_a(input logic [127:0] pt, input logic [127:0] ct, input int hold);
        chk("a_idle_in_ready", {127'h0, in_ready_a}, 128'h1);
        chk("a_idle_rk_idx", {124'h0, rk_idx_a}, 128'h0);
        in_valid_a  = 1'b1;
        in_block_a  = pt;
        out_ready_a = 1'b0;
        sb_a.push_back(ct);
        step();
        for (int k = 1; k <= 10; k++) begin
            chk("a_rk_idx", {124'h0, rk_idx_a}, 128'(k));
            chk("a_round_final", {127'h0, round_final_a}, {127'h0, (k == 10)});
            chk("a_round_out_valid", {127'h0, out_valid_a}, 128'h0);
            chk("a_round_in_ready", {127'h0, in_ready_a}, 128'h0);
            chk("a_round_busy", {127'h0, busy_a}, 128'h1);
            // Garbage offered while busy must be ignored; out_ready pulses must be harmless.
            in_block_a  = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready_a = (k % 2 == 1);
            step();
        end
        in_valid_a  = 1'b0;
        chk("a_latency_out_valid", {127'h0, out_valid_a}, 128'h1);
        chk("a_done_out_block", out_block_a, ct);
        chk("a_done_round_final", {127'h0, round_final_a}, 128'h0);
        out_ready_a = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("a_hold_out_valid", {127'h0, out_valid_a}, 128'h1);
            chk("a_hold_out_block", out_block_a, ct);
            chk("a_hold_in_ready", {127'h0, in_ready_a}, 128'h0);
            chk("a_hold_busy", {127'h0, busy_a}, 128'h1);
        end
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        chk("a_back_idle_in_ready", {127'h0, in_ready_a}, 128'h1);
        chk("a_back_idle_out_valid", {127'h0, out_valid_a}, 128'h0);
        chk("a_back_idle_busy", {127'h0, busy_a}, 128'h0);
        chk("a_back_idle_out_block", out_block_a, 128'h0);
    endtask

    // Watchdog: the run is a fixed-length directed sequence, so this only fires on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        logic [127:0] blk;

        expand_key(KEY128, 4, 10);
        for (int r = 0; r <= 10; r++) rk10_flat[128*r +: 128] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
        expand_key(KEY256, 8, 14);
        for (int r = 0; r <= 14; r++) rk14_flat[128*r +: 128] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};

        // Reset and idle state.
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {127'h0, in_ready_a}, 128'h1);
        chk("rst_out_valid", {127'h0, out_valid_a}, 128'h0);
        chk("rst_busy", {127'h0, busy_a}, 128'h0);
        chk("rst_round_final", {127'h0, round_final_a}, 128'h0);
        chk("rst_rk_idx", {124'h0, rk_idx_a}, 128'h0);
        chk("rst_round_in", round_in_a, 128'h0);
        chk("rst_out_block", out_block_a, 128'h0);
        chk("rst_b_in_ready", {127'h0, in_ready_b}, 128'h1);
        chk("rst_b_busy", {127'h0, busy_b}, 128'h0);

        // FIPS-197 AES-128 vector.
        run_a(PT, CT10, 0);

        // FIPS-197 AES-256 vector on the NR=14 instance.
        in_valid_b = 1'b1;
        in_block_b = PT;
        step();
        in_valid_b = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            chk("b_rk_idx", {124'h0, rk_idx_b}, 128'(k));
            chk("b_round_final", {127'h0, round_final_b}, {127'h0, (k == 14)});
            chk("b_round_out_valid", {127'h0, out_valid_b}, 128'h0);
            step();
        end
        chk("b_latency_out_valid", {127'h0, out_valid_b}, 128'h1);
        chk("b_out_block", out_block_b, CT14);
        out_ready_b = 1'b1;
        step();
        out_ready_b = 1'b0;
        chk("b_back_idle_out_valid", {127'h0, out_valid_b}, 128'h0);
        chk("b_back_idle_in_ready", {127'h0, in_ready_b}, 128'h1);

        // out_ready while idle has no effect.
        out_ready_a = 1'b1;
        step();
        chk("a_idle_ready_out_valid", {127'h0, out_valid_a}, 128'h0);
        chk("a_idle_ready_busy", {127'h0, busy_a}, 128'h0);
        out_ready_a = 1'b0;
        step();
        chk("a_idle_ready_in_ready", {127'h0, in_ready_a}, 128'h1);

        // Consumer back-pressure for 7 cycles.
        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_a(blk, enc10(blk), 7);

        // Asynchronous reset in round 5 discards the in-flight block.
        in_valid_a = 1'b1;
        in_block_a = PT;
        step();
        in_valid_a = 1'b0;
        repeat (4) step();
        chk("a_pre_reset_rk_idx", {124'h0, rk_idx_a}, 128'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_async_rst_out_valid", {127'h0, out_valid_a}, 128'h0);
        chk("a_async_rst_in_ready", {127'h0, in_ready_a}, 128'h1);
        chk("a_async_rst_busy", {127'h0, busy_a}, 128'h0);
        chk("a_async_rst_rk_idx", {124'h0, rk_idx_a}, 128'h0);
        chk("a_async_rst_round_in", round_in_a, 128'h0);
        step();
        rst_n = 1'b1;
        step();
        run_a(PT, CT10, 0);

        // in_valid held high with a fresh block each cycle: accepts every 12 cycles.
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        for (int c = 0; c < 36; c++) begin
            blk = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_block_a = blk;
            if (c % 12 == 0) begin
                chk("a_b2b_accept", {127'h0, in_ready_a}, 128'h1);
                sb_a.push_back(enc10(blk));
            end else begin
                chk("a_b2b_blocked", {127'h0, in_ready_a}, 128'h0);
            end
            step();
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        chk("a_b2b_end_in_ready", {127'h0, in_ready_a}, 128'h1);
        step();
        chk("a_sb_drained", 128'(sb_a.size()), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
